// File: rtl/avalon_s_pkg.sv
// Shared types and helpers for the Avalon multi-host front end.
package avalon_s_pkg;

  // Upper bound on the host count that the index helper can encode.
  localparam int MAX_HOSTS = 32;
  localparam int MAX_IDX_W = 5;

  // Lock state of the arbiter: a stalled transfer pins the grant.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Width of a host index (ptr, lock_id); never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Binary index of a one-hot vector; an all-zero vector yields 0.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_HOSTS-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_HOSTS; i++) begin
      idx = idx | (oh[i] ? MAX_IDX_W'(i) : {MAX_IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/avalon_s_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module avalon_s_rr_arbiter #(
  parameter int NH = 2,
  parameter int PW = 1
) (
  input  logic [NH-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NH-1:0] grant
);

  int   idx;
  logic found;

  // Scan ptr, ptr+1, ... with modulo-NH wrap and grant the first requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NH) begin
        idx = idx - NH;
      end else begin
        idx = idx;
      end
      for (int i = 0; i < NH; i++) begin
        if (!found && (i == idx) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end else begin
          grant[i] = grant[i];
        end
      end
    end
  end

endmodule

// File: rtl/avalon_s_host_arbiter.sv
// Merges NH Avalon host ports onto one bus port: round-robin grant,
// grant held while the bus stalls, read data steered back to its issuer.
module avalon_s_host_arbiter
  import avalon_s_pkg::*;
#(
  parameter int NH = 2,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NH-1:0]            hosts_avn_read,
  input  logic [NH-1:0]            hosts_avn_write,
  input  logic [NH-1:0][AW-1:0]    hosts_avn_address,
  input  logic [NH-1:0][DW/8-1:0]  hosts_avn_byte_enable,
  input  logic [NH-1:0][DW-1:0]    hosts_avn_writedata,
  output logic [NH-1:0][DW-1:0]    hosts_avn_readdata,
  output logic [NH-1:0]            hosts_avn_waitrequest,
  output logic                     bus_avn_read,
  output logic                     bus_avn_write,
  output logic [AW-1:0]            bus_avn_address,
  output logic [DW/8-1:0]          bus_avn_byte_enable,
  output logic [DW-1:0]            bus_avn_writedata,
  input  logic [DW-1:0]            bus_avn_readdata,
  input  logic                     bus_avn_waitrequest
);

  localparam int PW = idx_width(NH);
  localparam int BW = DW / 8;

  lock_state_e   state, state_next;
  logic [PW-1:0] ptr, ptr_next;
  logic [PW-1:0] lock_id, lock_id_next;
  logic [NH-1:0] rd_owner, rd_owner_next;
  logic [NH-1:0] req;
  logic [NH-1:0] rr_grant;
  logic [NH-1:0] grant;
  logic [NH-1:0] lock_oh;
  logic [PW-1:0] gnt_idx;
  logic          acc;

  assign req     = hosts_avn_read | hosts_avn_write;
  assign lock_oh = NH'(1'b1) << lock_id;
  assign gnt_idx = PW'(onehot_to_idx(MAX_HOSTS'(grant)));
  assign acc     = (|grant) & ~bus_avn_waitrequest;

  avalon_s_rr_arbiter #(
    .NH (NH),
    .PW (PW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (rr_grant)
  );

  // Final grant: the locked host while it keeps requesting, else the RR pick.
  // A locked host that drops its request aborts: nobody is granted this cycle.
  always_comb begin
    grant = '0;
    if (state == LOCKED) begin
      if (req[lock_id]) begin
        grant = lock_oh;
      end else begin
        grant = '0;
      end
    end else begin
      grant = rr_grant;
    end
  end

  // Forward the granted host's fields to the bus; zeros when nobody holds it.
  always_comb begin
    bus_avn_read        = 1'b0;
    bus_avn_write       = 1'b0;
    bus_avn_address     = '0;
    bus_avn_byte_enable = '0;
    bus_avn_writedata   = '0;
    for (int i = 0; i < NH; i++) begin
      bus_avn_read        = bus_avn_read  | (grant[i] & hosts_avn_read[i]);
      bus_avn_write       = bus_avn_write | (grant[i] & hosts_avn_write[i]);
      bus_avn_address     = bus_avn_address     | ({AW{grant[i]}} & hosts_avn_address[i]);
      bus_avn_byte_enable = bus_avn_byte_enable | ({BW{grant[i]}} & hosts_avn_byte_enable[i]);
      bus_avn_writedata   = bus_avn_writedata   | ({DW{grant[i]}} & hosts_avn_writedata[i]);
    end
  end

  // Host-side stall and read-data steering.
  always_comb begin
    hosts_avn_waitrequest = '1;
    hosts_avn_readdata    = '0;
    for (int i = 0; i < NH; i++) begin
      hosts_avn_waitrequest[i] = grant[i] ? bus_avn_waitrequest : 1'b1;
      hosts_avn_readdata[i]    = rd_owner[i] ? bus_avn_readdata : {DW{1'b0}};
    end
  end

  // Next-state for the lock FSM, round-robin pointer and read owner.
  always_comb begin
    state_next    = state;
    lock_id_next  = lock_id;
    ptr_next      = ptr;
    rd_owner_next = '0;

    case (state)
      UNLOCKED: begin
        if ((|grant) && bus_avn_waitrequest) begin
          state_next   = LOCKED;
          lock_id_next = gnt_idx;
        end else begin
          state_next   = UNLOCKED;
        end
      end
      LOCKED: begin
        if (!req[lock_id]) begin
          state_next = UNLOCKED;
        end else if (acc) begin
          state_next = UNLOCKED;
        end else begin
          state_next = LOCKED;
        end
      end
      default: begin
        state_next = UNLOCKED;
      end
    endcase

    // The host after the one just served gets first look next time.
    if (acc) begin
      ptr_next = (gnt_idx == PW'(NH - 1)) ? {PW{1'b0}} : (gnt_idx + PW'(1'b1));
    end else begin
      ptr_next = ptr;
    end

    // Read data arrives one cycle after acceptance; remember who asked.
    if (acc && bus_avn_read) begin
      rd_owner_next = grant;
    end else begin
      rd_owner_next = '0;
    end
  end

  // State registers with synchronous reset; reset drops any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNLOCKED;
      ptr      <= '0;
      lock_id  <= '0;
      rd_owner <= '0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      lock_id  <= lock_id_next;
      rd_owner <= rd_owner_next;
    end
  end

endmodule
